// File: rtl/ex_sched_if.sv
// ID-to-EX issue bus between the decode stage and the scheduler.
// master = ID side (drives decoded ops and jump_en), slave = scheduler.
interface ex_sched_if;
    logic       id_valid;
    logic       id_ready;
    logic [4:0] id_oh;
    logic [4:0] id_rd_addr;
    logic       id_rd_wen;
    logic       jump_en;
    logic [4:0] ex_oh;
    logic [4:0] ex_rd_addr;
    logic       ex_rd_wen;
    logic       ex_start;
    logic       hold_flag;
    logic       flush;
    logic       illegal_op;

    modport master (
        output id_valid, id_oh, id_rd_addr, id_rd_wen, jump_en,
        input  id_ready, ex_oh, ex_rd_addr, ex_rd_wen, ex_start, hold_flag, flush, illegal_op
    );

    modport slave (
        input  id_valid, id_oh, id_rd_addr, id_rd_wen, jump_en,
        output id_ready, ex_oh, ex_rd_addr, ex_rd_wen, ex_start, hold_flag, flush, illegal_op
    );
endinterface

// File: rtl/ex_sched.sv
// Issue scheduler between ID and EX: single-cycle ops stream back-to-back, multi-cycle
// ops hold the pipe with writeback deferred to completion, taken jumps flush for a while.
module ex_sched #(
    parameter int MC_CYCLES    = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int MC_OH_MIN    = 4,
    parameter int MC_OH_MAX    = 7
) (
    input logic      clk,
    input logic      rst,
    ex_sched_if.slave bus
);
    localparam int CNT_MAX = (MC_CYCLES > FLUSH_CYCLES) ? MC_CYCLES : FLUSH_CYCLES;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] MC_LOAD = CW'(MC_CYCLES - 1);
    localparam logic [CW-1:0] FL_LOAD = CW'(FLUSH_CYCLES - 1);
    localparam logic [4:0]    OH_MIN  = 5'(MC_OH_MIN);
    localparam logic [4:0]    OH_MAX  = 5'(MC_OH_MAX);

    typedef enum logic [1:0] {RUN, BUSY, FLUSH} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    oh_q, oh_d;
    logic [4:0]    rd_q, rd_d;
    logic          wen_q, wen_d;
    logic          wen_lat_q, wen_lat_d;
    logic          start_q, start_d;
    logic          hold_q, hold_d;
    logic          flush_q, flush_d;
    logic          ill_q, ill_d;
    logic          accept;

    assign bus.id_ready   = (state_q == RUN) && !bus.jump_en;
    assign accept         = bus.id_valid && bus.id_ready;
    assign bus.ex_oh      = oh_q;
    assign bus.ex_rd_addr = rd_q;
    assign bus.ex_rd_wen  = wen_q;
    assign bus.ex_start   = start_q;
    assign bus.hold_flag  = hold_q;
    assign bus.flush      = flush_q;
    assign bus.illegal_op = ill_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        oh_d      = oh_q;
        rd_d      = rd_q;
        wen_d     = wen_q;
        wen_lat_d = wen_lat_q;
        start_d   = 1'b0;
        ill_d     = 1'b0;
        hold_d    = hold_q;
        flush_d   = flush_q;
        case (state_q)
            RUN: begin
                // Bubble by default; only an accepted single/multi-cycle op loads EX.
                oh_d  = 5'd0;
                rd_d  = 5'd0;
                wen_d = 1'b0;
                if (bus.jump_en) begin
                    flush_d = 1'b1;
                    cnt_d   = FL_LOAD;
                    state_d = FLUSH;
                end else if (accept && bus.id_oh != 5'd0 && bus.id_oh < OH_MIN) begin
                    oh_d  = bus.id_oh;
                    rd_d  = bus.id_rd_addr;
                    wen_d = bus.id_rd_wen;
                end else if (accept && bus.id_oh >= OH_MIN && bus.id_oh <= OH_MAX) begin
                    oh_d      = bus.id_oh;
                    rd_d      = bus.id_rd_addr;
                    wen_lat_d = bus.id_rd_wen;
                    start_d   = 1'b1;
                    hold_d    = 1'b1;
                    cnt_d     = MC_LOAD;
                    state_d   = BUSY;
                end else if (accept && bus.id_oh > OH_MAX) begin
                    ill_d = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    wen_d   = wen_lat_q;
                    hold_d  = 1'b0;
                    state_d = RUN;
                end
            end
            FLUSH: begin
                oh_d  = 5'd0;
                rd_d  = 5'd0;
                wen_d = 1'b0;
                if (bus.jump_en) begin
                    cnt_d = FL_LOAD;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    flush_d = 1'b0;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            oh_q      <= 5'd0;
            rd_q      <= 5'd0;
            wen_q     <= 1'b0;
            wen_lat_q <= 1'b0;
            start_q   <= 1'b0;
            hold_q    <= 1'b0;
            flush_q   <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            oh_q      <= oh_d;
            rd_q      <= rd_d;
            wen_q     <= wen_d;
            wen_lat_q <= wen_lat_d;
            start_q   <= start_d;
            hold_q    <= hold_d;
            flush_q   <= flush_d;
            ill_q     <= ill_d;
        end
    end
endmodule

// File: tb/tb_ex_sched.sv
// Cycle-by-cycle vector table for ex_sched (MC_CYCLES=4, FLUSH_CYCLES=2) with a
// scoreboard of expected registered outputs, plus a reset-during-BUSY sequence.
module tb_ex_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    ex_sched_if bus ();

    ex_sched #(
        .MC_CYCLES   (4),
        .FLUSH_CYCLES(2),
        .MC_OH_MIN   (4),
        .MC_OH_MAX   (7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] oh;
        logic [4:0] rd;
        logic       wen;
        logic       start;
        logic       hold;
        logic       flush;
        logic       ill;
    } exp_t;

    typedef struct {
        logic       v;
        logic [4:0] oh;
        logic [4:0] rd;
        logic       wen;
        logic       jmp;
        logic       rdy;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[25];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, " ex_oh"},      int'(bus.ex_oh),      int'(e.oh));
        check({tag, " ex_rd_addr"}, int'(bus.ex_rd_addr), int'(e.rd));
        check({tag, " ex_rd_wen"},  int'(bus.ex_rd_wen),  int'(e.wen));
        check({tag, " ex_start"},   int'(bus.ex_start),   int'(e.start));
        check({tag, " hold_flag"},  int'(bus.hold_flag),  int'(e.hold));
        check({tag, " flush"},      int'(bus.flush),      int'(e.flush));
        check({tag, " illegal_op"}, int'(bus.illegal_op), int'(e.ill));
    endtask

    task automatic drive(input logic v, input logic [4:0] oh, input logic [4:0] rd,
                         input logic wen, input logic jmp);
        bus.id_valid   = v;
        bus.id_oh      = oh;
        bus.id_rd_addr = rd;
        bus.id_rd_wen  = wen;
        bus.jump_en    = jmp;
    endtask

    function automatic vec_t mk(input logic v, input int oh, input int rd, input logic wen,
                                input logic jmp, input logic rdy, input int eoh, input int erd,
                                input logic ewen, input logic est, input logic eh,
                                input logic ef, input logic ei);
        vec_t r;
        r.v = v; r.oh = 5'(oh); r.rd = 5'(rd); r.wen = wen; r.jmp = jmp; r.rdy = rdy;
        r.e.oh = 5'(eoh); r.e.rd = 5'(erd); r.e.wen = ewen; r.e.start = est;
        r.e.hold = eh; r.e.flush = ef; r.e.ill = ei;
        return r;
    endfunction

    initial begin
        exp_t zero_e;
        exp_t e;
        zero_e = '{oh: 5'd0, rd: 5'd0, wen: 1'b0, start: 1'b0, hold: 1'b0, flush: 1'b0, ill: 1'b0};

        //                v  oh rd wen jmp rdy | eoh erd ewen st hold fl ill
        vecs[0]  = mk(1, 2, 5, 1, 0, 1,   2, 5, 1, 0, 0, 0, 0);  // ADD
        vecs[1]  = mk(1, 3, 6, 1, 0, 1,   3, 6, 1, 0, 0, 0, 0);  // SUB back-to-back
        vecs[2]  = mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 4, 7, 1, 0, 1,   4, 7, 0, 1, 1, 0, 0);  // multi-cycle start
        vecs[4]  = mk(1, 2, 1, 1, 0, 0,   4, 7, 0, 0, 1, 0, 0);  // ignored while busy
        vecs[5]  = mk(0, 0, 0, 0, 0, 0,   4, 7, 0, 0, 1, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 1, 0,   4, 7, 0, 0, 1, 0, 0);  // jump ignored in BUSY
        vecs[7]  = mk(0, 0, 0, 0, 0, 0,   4, 7, 1, 0, 0, 0, 0);  // writeback
        vecs[8]  = mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0);
        vecs[9]  = mk(1, 1, 3, 1, 1, 0,   0, 0, 0, 0, 0, 1, 0);  // op dropped by jump
        vecs[10] = mk(1, 1, 3, 1, 0, 0,   0, 0, 0, 0, 0, 1, 0);
        vecs[11] = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);  // back to RUN
        vecs[12] = mk(1, 9, 4, 1, 0, 1,   0, 0, 0, 0, 0, 0, 1);  // illegal
        vecs[13] = mk(1, 1, 8, 1, 0, 1,   1, 8, 1, 0, 0, 0, 0);
        vecs[14] = mk(1, 2, 9, 0, 0, 1,   2, 9, 0, 0, 0, 0, 0);
        vecs[15] = mk(0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 1, 0);
        vecs[16] = mk(0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 1, 0);  // reload flush count
        vecs[17] = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0);
        vecs[18] = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        vecs[19] = mk(1, 7, 10, 0, 0, 1,  7, 10, 0, 1, 1, 0, 0); // top multi-cycle code
        vecs[20] = mk(0, 0, 0, 0, 0, 0,   7, 10, 0, 0, 1, 0, 0);
        vecs[21] = mk(0, 0, 0, 0, 0, 0,   7, 10, 0, 0, 1, 0, 0);
        vecs[22] = mk(0, 0, 0, 0, 0, 0,   7, 10, 0, 0, 1, 0, 0);
        vecs[23] = mk(0, 0, 0, 0, 0, 0,   7, 10, 0, 0, 0, 0, 0); // wen latched as 0
        vecs[24] = mk(1, 0, 2, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0);  // oh=0 is a bubble

        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_outputs("reset", zero_e);
        check("reset id_ready", int'(bus.id_ready), 1);
        $display("reset: ex_oh=%0d id_ready=%0d", bus.ex_oh, bus.id_ready);

        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].v, vecs[i].oh, vecs[i].rd, vecs[i].wen, vecs[i].jmp);
            #1;
            check($sformatf("vec%0d id_ready", i), int'(bus.id_ready), int'(vecs[i].rdy));
            sb.push_back(vecs[i].e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check_outputs($sformatf("vec%0d", i), e);
            $display("vec%0d: in v=%0d oh=%0d jmp=%0d -> ex_oh=%0d rd=%0d wen=%0d st=%0d hold=%0d fl=%0d ill=%0d",
                     i, vecs[i].v, vecs[i].oh, vecs[i].jmp, bus.ex_oh, bus.ex_rd_addr,
                     bus.ex_rd_wen, bus.ex_start, bus.hold_flag, bus.flush, bus.illegal_op);
        end

        // Reset two cycles into BUSY must abort the op without writeback or pulses.
        drive(1, 5, 11, 1, 0);
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0);
        check("rstbusy ex_start", int'(bus.ex_start), 1);
        @(posedge clk);
        #1;
        check("rstbusy hold", int'(bus.hold_flag), 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_outputs("rstbusy after", zero_e);
        check("rstbusy id_ready", int'(bus.id_ready), 1);
        $display("rstbusy: reset applied mid-BUSY, ex_rd_wen=%0d hold=%0d", bus.ex_rd_wen, bus.hold_flag);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("rstbusy idle%0d wen", k), int'(bus.ex_rd_wen), 0);
            check($sformatf("rstbusy idle%0d start", k), int'(bus.ex_start), 0);
            check($sformatf("rstbusy idle%0d hold", k), int'(bus.hold_flag), 0);
            $display("rstbusy idle%0d: wen=%0d start=%0d hold=%0d", k, bus.ex_rd_wen,
                     bus.ex_start, bus.hold_flag);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
